spi_con: RTL and testbench
==========================

# spi_con

SPI master controller (mode 0: CPOL=0, CPHA=0) for off-chip sensor/peripheral traffic. On a one-cycle trigger it drops chip select and shifts a `DATA_WIDTH`-bit word out MSB-first on `chip_data_out` while capturing the same number of bits from `chip_data_in`. It then returns the received word with a one-cycle valid strobe. It sits between the system-clock control logic and the SPI pins. Its half-period and bit counters are the event-counting stages that pace the serial clock.

## Interface
- `DATA_WIDTH`, default 8: bits per transfer; must be ≥ 1.
- `DATA_CLK_PERIOD`, default 100: system cycles per `chip_clk_out` period; must be even and ≥ 2. HALF = `DATA_CLK_PERIOD`/2.
- `clk_in`  input  1: system clock; all logic is on the rising edge.
- `rst_n_in`  input  1: reset, asynchronous, active-low.
- `data_in`  input  `DATA_WIDTH`: word to transmit; latched on an accepted trigger.
- `trigger_in`  input  1: start request; accepted only when `busy_out`=0.
- `data_out`  output  `DATA_WIDTH`: last received word; holds until the next completion.
- `data_valid_out`  output  1: one-cycle strobe marking `data_out` updated.
- `busy_out`  output  1: high from the cycle after acceptance through the final falling edge.
- `chip_data_out`  output  1: MOSI.
- `chip_data_in`  input  1: MISO.
- `chip_clk_out`  output  1: DCLK, idle low.
- `chip_sel_out`  output  1: CS, active-low, idle high.

## Operation
- Two states: IDLE and TRANSFER.
- Reset values (asynchronous on `rst_n_in`=0):
  - State IDLE.
  - `data_out`=0, `data_valid_out`=0, `busy_out`=0.
  - `chip_data_out`=0, `chip_clk_out`=0, `chip_sel_out`=1.
  - Internal counters and shift registers cleared.
- IDLE → TRANSFER, when `trigger_in`=1 in IDLE:
  - Latch `data_in` into the TX shift register.
  - Next cycle: `chip_sel_out`=0, `busy_out`=1, `chip_data_out`=`data_in[DATA_WIDTH-1]`, `chip_clk_out`=0.
  - Half counter and bit counter are 0.
- Half counter, width `$clog2(HALF)` (minimum 1):
  - Each TRANSFER cycle: if count = HALF-1, wrap to 0 and toggle `chip_clk_out`; otherwise increment.
- Rising toggle (0→1):
  - `chip_data_in` is shifted into the RX register LSB-side, sampled in the same cycle the toggle is registered.
- Falling toggle (1→0):
  - Bit counter increments; width `$clog2(DATA_WIDTH+1)`.
  - If bit counter < `DATA_WIDTH`, the TX register shifts left and `chip_data_out` takes the next bit.
- Completion, on the falling toggle that makes bit count = `DATA_WIDTH`:
  - Go to IDLE.
  - `chip_sel_out`=1, `busy_out`=0, `chip_data_out`=0.
  - `data_out` = RX register, including the bit captured on the last rising edge.
  - `data_valid_out`=1 for exactly that one cycle.
- `trigger_in` while in TRANSFER, including the completion cycle, is ignored; no queuing.
- `data_in` changes after acceptance have no effect on the transfer in progress.
- Reset asserted mid-transfer:
  - Immediate abort to the reset values.
  - No `data_valid_out`; `data_out` is cleared to 0.

## Timing
Trigger sampled at edge T.
- T+1: CS low, MSB on MOSI, `busy_out`=1.
- Bit k rising edge (k=0..`DATA_WIDTH`-1): T+1+HALF+k·`DATA_CLK_PERIOD`.
- Bit k falling edge: T+1+(k+1)·`DATA_CLK_PERIOD`.
- Completion: T+1+`DATA_WIDTH`·`DATA_CLK_PERIOD`. At that edge CS goes high, `data_valid_out`=1 and `busy_out`=0.
- Next trigger accepted at the completion edge +1 at the earliest. Its CS-low appears one cycle later, so CS is high for at least 1 cycle between transfers.
- MOSI is stable for HALF cycles before and after every rising edge.
- `DATA_CLK_PERIOD`=2: DCLK toggles every cycle.
- `DATA_CLK_PERIOD` constraints (even, ≥ 2) are checked by the bench only; no RTL handling of illegal values is required.

## Test plan
- Loopback, `DATA_WIDTH`=8, `DATA_CLK_PERIOD`=4, MISO tied to MOSI, `data_in`=0xA5, trigger at T → exactly 8 DCLK rising edges, `data_out`=0xA5 and `data_valid_out`=1 at T+33 only, CS low over T+1..T+32.
- MISO held 1, `data_in`=0x00 → MOSI 0 throughout, `data_out`=0xFF. MISO held 0, `data_in`=0xFF → `data_out`=0x00.
- `trigger_in` pulsed at T+10 and at the completion cycle with `data_in` changed → both ignored, MOSI bit pattern unchanged, single valid strobe.
- `rst_n_in` low at T+15 for 1 cycle → all outputs at reset values immediately, no valid strobe. A new trigger afterward completes normally 1+8·4 cycles later.
- `DATA_CLK_PERIOD`=2, `DATA_WIDTH`=12, scripted MISO 0xC3A, back-to-back triggers held high → `data_out`=0xC3A each transfer, transfer length 25 cycles, CS high exactly 1 cycle between transfers.

Source files
------------

// File: rtl/spi_con.sv
// rtl/spi_con.sv - SPI mode-0 master: one DATA_WIDTH-bit full-duplex transfer per trigger
module spi_con #(
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_CLK_PERIOD = 100
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  trigger_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  busy_out,
    output logic                  chip_data_out,
    input  logic                  chip_data_in,
    output logic                  chip_clk_out,
    output logic                  chip_sel_out
);
    localparam int HALF = DATA_CLK_PERIOD / 2;
    localparam int HC_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BC_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, TRANSFER} state_t;

    state_t                state, state_next;
    logic [HC_W-1:0]       half_cnt;
    logic [BC_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_next;
    logic                  half_wrap;
    logic                  fall_edge;
    logic                  last_fall;

    assign half_wrap = (half_cnt == HC_W'(HALF - 1));
    assign fall_edge = (state == TRANSFER) && half_wrap && chip_clk_out;
    assign last_fall = fall_edge && (bit_cnt == BC_W'(DATA_WIDTH - 1));
    assign tx_next   = tx_shift << 1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (trigger_in) state_next = TRANSFER;
            TRANSFER: if (last_fall) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs are registered so the pins never glitch; the MSB is presented
    // together with CS falling, giving a full half period of setup.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            half_cnt       <= '0;
            bit_cnt        <= '0;
            tx_shift       <= '0;
            rx_shift       <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            busy_out       <= 1'b0;
            chip_data_out  <= 1'b0;
            chip_clk_out   <= 1'b0;
            chip_sel_out   <= 1'b1;
        end else begin
            data_valid_out <= 1'b0;
            if (state == IDLE) begin
                if (trigger_in) begin
                    tx_shift      <= data_in;
                    rx_shift      <= '0;
                    half_cnt      <= '0;
                    bit_cnt       <= '0;
                    chip_sel_out  <= 1'b0;
                    busy_out      <= 1'b1;
                    chip_data_out <= data_in[DATA_WIDTH-1];
                    chip_clk_out  <= 1'b0;
                end
            end else if (!half_wrap) begin
                half_cnt <= half_cnt + 1'b1;
            end else begin
                half_cnt     <= '0;
                chip_clk_out <= ~chip_clk_out;
                if (!chip_clk_out) begin
                    rx_shift <= (rx_shift << 1) | DATA_WIDTH'(chip_data_in);
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_fall) begin
                        chip_sel_out   <= 1'b1;
                        busy_out       <= 1'b0;
                        chip_data_out  <= 1'b0;
                        data_out       <= rx_shift;
                        data_valid_out <= 1'b1;
                    end else begin
                        tx_shift      <= tx_next;
                        chip_data_out <= tx_next[DATA_WIDTH-1];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_con.sv
// tb/tb_spi_con.sv - scoreboard bench for spi_con with a behavioural SPI slave
module tb_spi_con;
    localparam int AW = 8;
    localparam int AP = 4;
    localparam int BW = 12;
    localparam int BP = 2;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic pick(input logic [31:0] w, input int width, input int idx);
        if (idx < 0 || idx >= width) return 1'b0;
        return w[width-1-idx];
    endfunction

    // ---------------- DUT A: 8 bits, period 4 ----------------
    logic          a_rst_n, a_trig, a_valid, a_busy, a_mosi, a_miso, a_dclk, a_cs, a_loop;
    logic [AW-1:0] a_din, a_dout, a_sw, a_cap;
    int            a_sidx, a_rises, a_cslow;

    assign a_miso = a_loop ? a_mosi : pick(32'(a_sw), AW, a_sidx);

    spi_con #(.DATA_WIDTH(AW), .DATA_CLK_PERIOD(AP)) u_a (
        .clk_in(clk_in), .rst_n_in(a_rst_n), .data_in(a_din), .trigger_in(a_trig),
        .data_out(a_dout), .data_valid_out(a_valid), .busy_out(a_busy),
        .chip_data_out(a_mosi), .chip_data_in(a_miso), .chip_clk_out(a_dclk),
        .chip_sel_out(a_cs)
    );

    typedef struct {
        logic [AW-1:0] rx;
        logic [AW-1:0] tx;
        int            vcyc;
    } a_exp_t;
    a_exp_t a_q[$];

    // Mode-0 slave: samples MOSI on DCLK rise, advances MISO after DCLK fall.
    initial begin : slave_a
        logic pd, pcs;
        pd = 1'b0; pcs = 1'b1; a_sidx = 0; a_rises = 0; a_cslow = 0; a_cap = '0;
        forever begin
            @(negedge clk_in);
            if (pcs && !a_cs) begin
                a_rises = 0; a_cslow = 0; a_cap = '0;
            end
            if (a_cs) begin
                a_sidx = 0;
            end else begin
                a_cslow++;
                if (!pd && a_dclk) begin
                    a_cap = {a_cap[AW-2:0], a_mosi};
                    a_rises++;
                end
                if (pd && !a_dclk) a_sidx++;
            end
            pd = a_dclk; pcs = a_cs;
        end
    end

    initial begin : monitor_a
        a_exp_t e;
        forever begin
            @(negedge clk_in);
            if (a_valid) begin
                if (a_q.size() == 0) begin
                    check("a_unexpected_valid", 32'(a_q.size()), 32'd1);
                end else begin
                    e = a_q.pop_front();
                    check("a_data_out", 32'(a_dout), 32'(e.rx));
                    check("a_mosi_bits", 32'(a_cap), 32'(e.tx));
                    check("a_valid_cycle", 32'(cyc), 32'(e.vcyc));
                    check("a_dclk_rises", 32'(a_rises), 32'(AW));
                    check("a_cs_low_cycles", 32'(a_cslow), 32'(AW * AP));
                    check("a_cs_at_done", 32'(a_cs), 32'd1);
                    check("a_busy_at_done", 32'(a_busy), 32'd0);
                end
            end
        end
    end

    task automatic a_xfer(input logic [AW-1:0] din, input logic [AW-1:0] sw,
                          input logic loop, input logic glitch);
        int t;
        a_exp_t e;
        @(negedge clk_in);
        a_din = din; a_sw = sw; a_loop = loop; a_trig = 1'b1; t = cyc;
        e.rx = loop ? din : sw; e.tx = din; e.vcyc = t + 1 + AW * AP;
        a_q.push_back(e);
        @(negedge clk_in);
        a_trig = 1'b0;
        if (glitch) begin
            while (cyc < t + 10) @(negedge clk_in);
            a_trig = 1'b1; a_din = ~din;
            @(negedge clk_in);
            a_trig = 1'b0;
            while (cyc < t + AW * AP) @(negedge clk_in);
            a_trig = 1'b1;
            @(negedge clk_in);
            a_trig = 1'b0;
        end
        while (cyc < t + 2 + AW * AP) @(negedge clk_in);
    endtask

    // ---------------- DUT B: 12 bits, period 2 ----------------
    logic          b_rst_n, b_trig, b_valid, b_busy, b_mosi, b_miso, b_dclk, b_cs;
    logic [BW-1:0] b_din, b_dout, b_sw, b_cap;
    int            b_sidx, b_rises, b_cshigh, b_nv, b_last, b_t0;

    assign b_miso = pick(32'(b_sw), BW, b_sidx);

    spi_con #(.DATA_WIDTH(BW), .DATA_CLK_PERIOD(BP)) u_b (
        .clk_in(clk_in), .rst_n_in(b_rst_n), .data_in(b_din), .trigger_in(b_trig),
        .data_out(b_dout), .data_valid_out(b_valid), .busy_out(b_busy),
        .chip_data_out(b_mosi), .chip_data_in(b_miso), .chip_clk_out(b_dclk),
        .chip_sel_out(b_cs)
    );

    initial begin : slave_b
        logic pd, pcs;
        pd = 1'b0; pcs = 1'b1; b_sidx = 0; b_rises = 0; b_cshigh = 0; b_cap = '0;
        forever begin
            @(negedge clk_in);
            if (pcs && !b_cs) begin
                if (b_nv > 0) check("b_cs_high_gap", 32'(b_cshigh), 32'd1);
                b_cshigh = 0; b_rises = 0; b_cap = '0;
            end
            if (b_cs) begin
                b_cshigh++;
                b_sidx = 0;
            end else begin
                if (!pd && b_dclk) begin
                    b_cap = {b_cap[BW-2:0], b_mosi};
                    b_rises++;
                end
                if (pd && !b_dclk) b_sidx++;
            end
            pd = b_dclk; pcs = b_cs;
        end
    end

    initial begin : monitor_b
        b_nv = 0; b_last = 0;
        forever begin
            @(negedge clk_in);
            if (b_valid) begin
                check("b_data_out", 32'(b_dout), 32'h0000_0C3A);
                check("b_mosi_bits", 32'(b_cap), 32'(b_din));
                check("b_dclk_rises", 32'(b_rises), 32'(BW));
                if (b_nv == 0) check("b_first_latency", 32'(cyc - b_t0), 32'(1 + BW * BP));
                else           check("b_period", 32'(cyc - b_last), 32'(1 + BW * BP));
                b_last = cyc;
                b_nv++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int t, lim;
        a_rst_n = 1'b0; b_rst_n = 1'b0; a_trig = 1'b0; b_trig = 1'b0;
        a_din = '0; a_sw = '0; a_loop = 1'b0;
        b_din = BW'($urandom); b_sw = 12'hC3A; b_t0 = 0;
        repeat (3) @(negedge clk_in);
        check("rst_cs", 32'(a_cs), 32'd1);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_dclk", 32'(a_dclk), 32'd0);
        check("rst_mosi", 32'(a_mosi), 32'd0);
        check("rst_data_out", 32'(a_dout), 32'd0);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_b_cs", 32'(b_cs), 32'd1);
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        a_xfer(8'hA5, 8'h00, 1'b1, 1'b0);
        a_xfer(8'h00, 8'hFF, 1'b0, 1'b0);
        a_xfer(8'hFF, 8'h00, 1'b0, 1'b0);
        a_xfer(8'h3C, 8'h96, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            a_xfer(AW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        a_xfer(8'hA5, 8'h00, 1'b1, 1'b0);

        // Abort mid-transfer: nothing is queued, so any later strobe is flagged.
        @(negedge clk_in);
        a_din = 8'h77; a_loop = 1'b1; a_trig = 1'b1; t = cyc;
        @(negedge clk_in);
        a_trig = 1'b0;
        while (cyc < t + 15) @(negedge clk_in);
        check("abort_busy_before", 32'(a_busy), 32'd1);
        a_rst_n = 1'b0;
        #1;
        check("abort_cs", 32'(a_cs), 32'd1);
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_dclk", 32'(a_dclk), 32'd0);
        check("abort_mosi", 32'(a_mosi), 32'd0);
        check("abort_data_out", 32'(a_dout), 32'd0);
        check("abort_valid", 32'(a_valid), 32'd0);
        @(negedge clk_in);
        a_rst_n = 1'b1;
        a_xfer(8'h5A, 8'hC3, 1'b0, 1'b0);
        check("a_pending", 32'(a_q.size()), 32'd0);

        @(negedge clk_in);
        b_trig = 1'b1; b_t0 = cyc;
        lim = cyc + 5 * (1 + BW * BP) + 20;
        while (b_nv < 4 && cyc < lim) @(negedge clk_in);
        b_trig = 1'b0;
        repeat (2 * (1 + BW * BP)) @(negedge clk_in);
        check("b_transfers", 32'(b_nv >= 4), 32'd1);
        check("b_idle_cs", 32'(b_cs), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
